fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin arbiter that shares the write port of the async FIFO (fifo1)
//  between NREQ producers in the write clock domain. Grants one requester at
//  a time for a burst of up to MAX_BURST words and drives w_en/wdata. Never
//  writes while the FIFO reports full. Sits directly in front of fifo1 wdata/w_en/full.
// PARAMETERS
//  DATA_SIZE  8  width of each data word (matches fifo1 DATA_SIZE)
//  NREQ       4  number of requesters (2..8)
//  MAX_BURST  4  max words written per grant (1..16)
//  CNT_W      16 width of total-write counter wr_count
// PORTS
//  wclk      in   1               write clock (only clock)
//  wrst_n    in   1               async active-low reset
//  req       in   NREQ            per-requester "word available" (level)
//  req_data  in   NREQ*DATA_SIZE  requester i word at [i*DATA_SIZE +: DATA_SIZE]
//  full      in   1               fifo1 full flag (wclk domain)
//  ack       out  NREQ            one-hot: word of requester i consumed this cycle
//  w_en      out  1               to fifo1 w_en
//  wdata     out  DATA_SIZE       to fifo1 wdata
//  grant_id  out  $clog2(NREQ)    current owner index (valid when busy)
//  busy      out  1               a grant is active
//  wr_count  out  CNT_W           total words written since reset, wraps
// BEHAVIOUR
//  - Reset (wrst_n=0, async): state=IDLE, rr_ptr=0, burst_cnt=0, grant_id=0,
//    wr_count=0; ack=0, w_en=0, busy=0, wdata=0. Reset mid-burst drops the grant;
//    no partial write is issued in the reset cycle.
//  - States: IDLE, GRANT.
//  - IDLE: if |req, pick first i with req[i]=1 searching rr_ptr, rr_ptr+1, ...
//    mod NREQ; next cycle state=GRANT, grant_id=i, burst_cnt=0. No write in IDLE
//    (one-cycle arbitration bubble per grant). If req=0, stay IDLE.
//  - GRANT: w_en = req[grant_id] & ~full (combinational from regs + inputs);
//    wdata = req_data slice of grant_id; ack[grant_id] = w_en, all other ack=0.
//    On w_en: burst_cnt++, wr_count++ (mod 2^CNT_W).
//  - GRANT exit to IDLE, rr_ptr <= (grant_id+1) mod NREQ, when:
//    (a) w_en & burst_cnt==MAX_BURST-1 (burst done, this word still written), or
//    (b) req[grant_id]=0 (owner withdrew; no write that cycle).
//  - full=1 in GRANT with req held: stall; hold grant, burst_cnt unchanged,
//    w_en=0, ack=0. Grant is not lost to full.
//  - full and req drop in same cycle: rule (b) applies, release grant.
//  - Other requesters' req are ignored during GRANT; they are served in RR
//    order after release. No requester waits more than NREQ-1 grants.
//  - busy = (state==GRANT). Outputs w_en/wdata/ack are never X after reset.
//  - Requesters must hold req_data stable while req=1 and ack=0.
//  - Throughput: MAX_BURST words per MAX_BURST+1 cycles under no backpressure.
// TESTING (NREQ=4, DATA_SIZE=8, MAX_BURST=4)
//  1 Reset: wrst_n=0 async mid-cycle -> w_en=0, ack=0, busy=0, wr_count=0 at once.
//  2 Single req[2]=1 held, data 8'hA5, full=0 -> IDLE 1 cyc, then 4 writes of
//    A5 with ack=4'b0100, 1 idle cyc, re-grant to 2; wr_count=8 after 10 cycles.
//  3 req=4'b1111 held -> grants in order 0,1,2,3,0 each 4 words; ack one-hot,
//    never two bits set.
//  4 req[1] granted, full=1 after 2 writes for 5 cycles -> w_en=0, grant_id=1
//    held; after full=0, exactly 2 more words then release to requester 2.
//  5 req[3] dropped after 1 write -> release next cycle, rr_ptr=0, burst_cnt
//    resets on next grant; no extra ack to 3.
//  6 CNT_W=4, 17 writes -> wr_count wraps 15->0, reads 1.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the fifo1 write port between NREQ producers.
// A requester keeps its grant for up to MAX_BURST words, stalls on full, and releases when it withdraws.
module fifo_wr_arbiter #(
  parameter int DATA_SIZE = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 16
) (
  input  logic                      wclk,
  input  logic                      wrst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*DATA_SIZE-1:0] req_data,
  input  logic                      full,
  output logic [NREQ-1:0]           ack,
  output logic                      w_en,
  output logic [DATA_SIZE-1:0]      wdata,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy,
  output logic [CNT_W-1:0]          wr_count
);

  localparam int GID_W  = $clog2(NREQ);
  localparam int BCNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  state_e             state_q,     state_d;
  logic [GID_W-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [GID_W-1:0]   grant_id_q,  grant_id_d;
  logic [BCNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [CNT_W-1:0]   wr_count_q,  wr_count_d;

  logic                 owner_req;
  logic [DATA_SIZE-1:0] owner_data;
  logic                 w_en_c;
  logic                 last_word;
  logic [GID_W-1:0]     next_id;
  logic                 pick_valid;
  logic [GID_W-1:0]     pick_id;
  logic [NREQ-1:0]      ack_c;

  // Owner's request/data, and the one-hot ack for the word written this cycle.
  always_comb begin
    owner_req  = 1'b0;
    owner_data = '0;
    ack_c      = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id_q == GID_W'(i)) begin
        owner_req  = req[i];
        owner_data = req_data[i*DATA_SIZE +: DATA_SIZE];
        ack_c[i]   = w_en_c;
      end
    end
  end

  assign w_en_c    = (state_q == GRANT) && owner_req && !full;
  assign last_word = (burst_cnt_q == BCNT_W'(MAX_BURST - 1));
  assign next_id   = (grant_id_q == GID_W'(NREQ - 1)) ? '0 : grant_id_q + 1'b1;

  // Descending search so the candidate closest to rr_ptr is assigned last and wins.
  always_comb begin
    logic [GID_W-1:0] cand;
    cand       = '0;
    pick_valid = 1'b0;
    pick_id    = rr_ptr_q;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = GID_W'((int'(rr_ptr_q) + k) % NREQ);
      if (req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = cand;
      end
    end
  end

  // NOTE: every next-state variable takes its current value first, so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    burst_cnt_d = burst_cnt_q;
    wr_count_d  = wr_count_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d     = GRANT;
          grant_id_d  = pick_id;
          burst_cnt_d = '0;
        end
      end
      GRANT: begin
        if (!owner_req) begin
          state_d  = IDLE;
          rr_ptr_d = next_id;
        end else if (w_en_c) begin
          wr_count_d  = wr_count_q + 1'b1;
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (last_word) begin
            state_d  = IDLE;
            rr_ptr_d = next_id;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of block evaluation order.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      burst_cnt_q <= '0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      burst_cnt_q <= burst_cnt_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign w_en     = w_en_c;
  assign ack      = ack_c;
  assign wdata    = (state_q == GRANT) ? owner_data : '0;
  assign grant_id = grant_id_q;
  assign busy     = (state_q == GRANT);
  assign wr_count = wr_count_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic checked against a
// transaction-level model through a scoreboard queue; a CNT_W=4 copy checks counter wrap.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;

  logic              wclk = 1'b0;
  logic              wrst_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic              full = 1'b0;

  logic [NR-1:0]     ack,  ack4;
  logic              w_en, w_en4;
  logic [DW-1:0]     wdata, wdata4;
  logic [1:0]        grant_id, grant_id4;
  logic              busy, busy4;
  logic [15:0]       wr_count;
  logic [3:0]        wr_count4;

  fifo_wr_arbiter #(.DATA_SIZE(DW), .NREQ(NR), .MAX_BURST(MB), .CNT_W(16)) u_dut (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .full(full),
    .ack(ack), .w_en(w_en), .wdata(wdata), .grant_id(grant_id), .busy(busy),
    .wr_count(wr_count)
  );

  fifo_wr_arbiter #(.DATA_SIZE(DW), .NREQ(NR), .MAX_BURST(MB), .CNT_W(4)) u_dut4 (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .full(full),
    .ack(ack4), .w_en(w_en4), .wdata(wdata4), .grant_id(grant_id4), .busy(busy4),
    .wr_count(wr_count4)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    bit          wen;
    int          owner;
    logic [7:0]  data;
    bit          busy;
    int          count;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Transaction-level model: who owns the port, how many words it has written,
  // who is next in line, and how many words went out in total.
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_words = 0;
  int m_ptr   = 0;
  int m_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic release_owner();
    m_busy = 1'b0;
    m_ptr  = (m_owner + 1) % NR;
  endtask

  task automatic model_step();
    exp_t e;
    int   c;
    if (!wrst_n) begin
      m_busy = 1'b0; m_owner = 0; m_words = 0; m_ptr = 0; m_count = 0;
      e = '{wen: 1'b0, owner: 0, data: 8'h00, busy: 1'b0, count: 0};
    end else begin
      e = '{wen: 1'b0, owner: m_owner, data: 8'h00, busy: m_busy, count: m_count};
      if (!m_busy) begin
        for (int k = 0; k < NR; k++) begin
          c = (m_ptr + k) % NR;
          if (req[c]) begin
            m_owner = c; m_busy = 1'b1; m_words = 0;
            break;
          end
        end
      end else if (!req[m_owner]) begin
        release_owner();
      end else if (!full) begin
        e.wen  = 1'b1;
        e.data = req_data[m_owner*DW +: DW];
        m_count++;
        m_words++;
        if (m_words == MB) release_owner();
      end
    end
    sb.push_back(e);
  endtask

  initial begin
    forever begin
      @(negedge wclk);
      model_step();
    end
  end

  // Monitor: one expectation per cycle, compared just after the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge wclk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("w_en", 32'(w_en), 32'(e.wen));
        check("ack", 32'(ack), e.wen ? (32'd1 << e.owner) : 32'd0);
        check("busy", 32'(busy), 32'(e.busy));
        check("wr_count", 32'(wr_count), 32'(e.count % 65536));
        check("wr_count_wrap4", 32'(wr_count4), 32'(e.count % 16));
        if (e.busy) check("grant_id", 32'(grant_id), 32'(e.owner));
        if (e.wen)  check("wdata", 32'(wdata), 32'(e.data));
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge wclk);
      #1;
    end
  endtask

  task automatic wait_writes(input int n);
    int seen;
    int budget;
    seen = 0;
    budget = 0;
    while (seen < n && budget < 50) begin
      @(negedge wclk);
      #2;
      if (w_en) seen++;
      budget++;
    end
    check("wait_writes", 32'(seen), 32'(n));
    @(posedge wclk);
    #1;
  endtask

  task automatic random_step();
    logic [NR-1:0] a;
    @(negedge wclk);
    #1;
    a = ack;
    @(posedge wclk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (req[i] && a[i]) begin
        if ($urandom_range(3) == 0) req[i] = 1'b0;
        else req_data[i*DW +: DW] = 8'($urandom);
      end else if (req[i]) begin
        if ($urandom_range(15) == 0) req[i] = 1'b0;
      end else if ($urandom_range(1) == 0) begin
        req[i] = 1'b1;
        req_data[i*DW +: DW] = 8'($urandom);
      end
    end
    full = ($urandom_range(3) == 0);
  endtask

  initial begin
    step(3);
    wrst_n = 1'b1;

    // Single requester 2: bubble, 4 writes, bubble, 4 writes.
    req_data[2*DW +: DW] = 8'hA5;
    req = 4'b0100;
    step(10);
    check("wr_count_after_10", 32'(wr_count), 32'd8);
    req = '0;
    step(3);

    // All requesters: rotating grants.
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = 8'(8'h10 + i);
    req = 4'b1111;
    step(30);
    req = '0;
    step(3);

    // Requester 1 stalled by full after 2 words, then finishes and hands to 2.
    req_data[1*DW +: DW] = 8'h3C;
    req = 4'b0010;
    wait_writes(2);
    full = 1'b1;
    req_data[2*DW +: DW] = 8'h77;
    req[2] = 1'b1;
    step(5);
    full = 1'b0;
    step(14);
    req = '0;
    step(3);

    // Requester 3 withdraws after one word.
    req_data[3*DW +: DW] = 8'h5E;
    req = 4'b1000;
    wait_writes(1);
    req[3] = 1'b0;
    step(4);

    // Asynchronous reset in the middle of a burst.
    req_data[0 +: DW] = 8'hC3;
    req = 4'b0001;
    wait_writes(1);
    @(posedge wclk);
    #3;
    wrst_n = 1'b0;
    #1;
    check("rst_w_en", 32'(w_en), 32'd0);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_count", 32'(wr_count), 32'd0);
    step(2);
    wrst_n = 1'b1;
    req = '0;
    step(2);

    // Random traffic with backpressure.
    repeat (3000) random_step();
    req = '0;
    full = 1'b0;
    step(6);
    check("scoreboard_drained", 32'(sb.size() <= 1), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
